// File: rtl/alu_seq_pkg.sv
// Shared types for the registered ALU: command encoding and FSM state constants.
package alu_seq_pkg;

  // Fixed encoding; codes 5..7 are reserved and reported as unsupported.
  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_NAND = 3'd2,
    CMD_SHFT = 3'd3,
    CMD_MUL  = 3'd4
  } alu_cmd_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq; master drives operands, slave is the ALU.
interface alu_seq_if #(
  parameter int D = 8
);
  localparam int SW = $clog2(D);

  // Immediate field: flag=1 selects right shift, shamt is the shift distance.
  typedef struct packed {
    logic          flag;
    logic [SW-1:0] shamt;
  } immed_t;

  logic                   in_valid;
  logic                   in_ready;
  logic [D-1:0]           a;
  logic [D-1:0]           b;
  immed_t                 n;
  alu_seq_pkg::alu_cmd_e  cmd;
  logic                   out_valid;
  logic                   out_ready;
  logic [D-1:0]           x;
  logic                   flag_z;
  logic                   flag_c;
  logic                   flag_n;
  logic                   err;

  modport master (
    output in_valid, a, b, n, cmd, out_ready,
    input  in_ready, out_valid, x, flag_z, flag_c, flag_n, err
  );

  modport slave (
    input  in_valid, a, b, n, cmd, out_ready,
    output in_ready, out_valid, x, flag_z, flag_c, flag_n, err
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, 2D-bit product.
module alu_mul_iter #(
  parameter int D = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [D-1:0]   a,
  input  logic [D-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*D-1:0] prod
);
  localparam int CW = $clog2(D + 1);

  logic           busy_q, busy_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*D-1:0] acc_q, acc_d;
  logic [2*D-1:0] mcand_q, mcand_d;
  logic [D-1:0]   mplier_q, mplier_d;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(D);
      acc_d    = '0;
      mcand_d  = {{D{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      // The cycle with cnt==0 is the done cycle; the consumer takes prod then.
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign busy = busy_q;
  assign done = busy_q & (cnt_q == '0);
  assign prod = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ready/valid ALU (ADD/SUB/NAND/SHFT, optional MUL) with Z/C/N flags.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise MUL reports err.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int D = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(D);

  logic [1:0]    state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [D-1:0]  x_q, x_d;
  logic          z_q, z_d, c_q, c_d, n_q, n_d, err_q, err_d;

  logic [D:0]    sum;
  logic [SW-1:0] shamt;
  logic [D-1:0]  op_x;
  logic          op_c, op_err;
  logic          in_ready, accept, mul_idle;

`ifdef ALU_MUL_EN
  logic           mul_start, mul_busy, mul_done;
  logic [2*D-1:0] mul_prod;

  alu_mul_iter #(.D(D)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign mul_idle = ~mul_busy;
`else
  assign mul_idle = 1'b1;
`endif

  // Single-cycle result, computed straight from the live operands.
  always_comb begin
    sum    = {1'b0, bus.a} + {1'b0, bus.b};
    shamt  = bus.n.shamt;
    op_x   = '0;
    op_c   = 1'b0;
    op_err = 1'b0;
    case (bus.cmd)
      CMD_ADD: begin
        op_x = sum[D-1:0];
        op_c = sum[D];
      end
      CMD_SUB: begin
        op_x = bus.a - bus.b;
        op_c = (bus.a >= bus.b);
      end
      CMD_NAND: op_x = ~(bus.a & bus.b);
      CMD_SHFT: begin
        if (32'(shamt) >= D) op_x = '0;
        else if (bus.n.flag) op_x = bus.a >> shamt;
        else                 op_x = bus.a << shamt;
      end
      default: op_err = 1'b1;
    endcase
  end

  // A slot opens when idle, or when the held result is being drained this cycle.
  assign in_ready = rst_n & mul_idle & (state_q != ST_MUL) & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    z_d         = z_q;
    c_d         = c_q;
    n_d         = n_q;
    err_d       = err_q;
`ifdef ALU_MUL_EN
    mul_start   = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (state_q == ST_HOLD && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
        if (accept) begin
`ifdef ALU_MUL_EN
          if (bus.cmd == CMD_MUL) begin
            mul_start   = 1'b1;
            out_valid_d = 1'b0;
            state_d     = ST_MUL;
          end else
`endif
          begin
            x_d         = op_x;
            z_d         = (op_x == '0);
            c_d         = op_c;
            n_d         = op_x[D-1];
            err_d       = op_err;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          x_d         = mul_prod[D-1:0];
          z_d         = (mul_prod[D-1:0] == '0);
          c_d         = |mul_prod[2*D-1:D];
          n_d         = mul_prod[D-1];
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      z_q         <= z_d;
      c_q         <= c_d;
      n_q         <= n_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_n    = n_q;
  assign bus.err       = err_q;

endmodule
